// File: rtl/load_unit_pkg.sv
// Shared load-path definitions: load op codes, FSM encodings, the memory map
// ranges and the address/alignment legality check used at acceptance.
package load_unit_pkg;

   typedef enum logic [2:0] {
      LOAD_NONE = 3'd0,
      LOAD_W    = 3'd1,
      LOAD_H    = 3'd2,
      LOAD_HU   = 3'd3,
      LOAD_B    = 3'd4,
      LOAD_BU   = 3'd5
   } load_size_e;

   typedef enum logic [1:0] {
      LU_IDLE = 2'd0,
      LU_WAIT = 2'd1,
      LU_DONE = 2'd2
   } lu_state_e;

   // DM starts at address 0, so only its upper bound is ever compared.
   localparam logic [31:0] DM_MSA  = 32'h0000_2FFF;
   localparam logic [31:0] T0_LSA  = 32'h0000_7F00;
   localparam logic [31:0] T0_MSA  = 32'h0000_7F0B;
   localparam logic [31:0] T1_LSA  = 32'h0000_7F10;
   localparam logic [31:0] T1_MSA  = 32'h0000_7F1B;
   localparam logic [31:0] INT_LSA = 32'h0000_7F20;
   localparam logic [31:0] INT_MSA = 32'h0000_7F23;

   function automatic logic in_range(input logic [31:0] a, input logic [31:0] lo,
                                     input logic [31:0] hi);
      return (a >= lo) && (a <= hi);
   endfunction

   // AdEL: unmapped address, misaligned word/half, or a sub-word timer access.
   function automatic logic load_fault(input logic [31:0] a, input load_size_e op);
      logic timer;
      logic mapped;
      timer  = in_range(a, T0_LSA, T0_MSA) || in_range(a, T1_LSA, T1_MSA);
      mapped = (a <= DM_MSA) || timer || in_range(a, INT_LSA, INT_MSA);
      return !mapped
          || ((op == LOAD_W) && (a[1:0] != 2'b00))
          || (((op == LOAD_H) || (op == LOAD_HU)) && a[0])
          || (timer && (op != LOAD_W));
   endfunction

endpackage

// File: rtl/load_unit_if.sv
// Word-read channel between the load unit (master) and the system bridge (slave).
interface load_unit_if;
   logic        bus_rd_req;
   logic [31:0] bus_addr;
   logic        bus_rd_ack;
   logic [31:0] bus_rd_data;

   modport master (output bus_rd_req, bus_addr, input bus_rd_ack, bus_rd_data);
   modport slave  (input bus_rd_req, bus_addr, output bus_rd_ack, bus_rd_data);
endinterface

// File: rtl/load_ext.sv
// Selects the byte/half/word addressed by the load offset from a raw bus word
// and sign- or zero-extends it to 32 bits.
module load_ext
   import load_unit_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  load_size_e  op,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the case can leave it unassigned and infer a latch.
   always_comb begin
      data     = '0;
      byte_sel = word[{offset, 3'b000} +: 8];
      half_sel = offset[1] ? word[31:16] : word[15:0];
      case (op)
         LOAD_W:  data = word;
         LOAD_H:  data = {{16{half_sel[15]}}, half_sel};
         LOAD_HU: data = {16'h0000, half_sel};
         LOAD_B:  data = {{24{byte_sel[7]}}, byte_sel};
         LOAD_BU: data = {24'h00_0000, byte_sel};
         default: data = '0;
      endcase
   end

endmodule

// File: rtl/load_unit.sv
// M-stage load unit: checks the address, issues one word read to the bridge,
// extends the returned data and presents a registered result with a valid pulse.
module load_unit
   import load_unit_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req,
   input  logic [31:0] addr,
   input  load_size_e  op,
   input  logic        flush,
   output logic        ready,
   output logic        stall,
   output logic [31:0] rdata,
   output logic        rvalid,
   output logic        exception,
   load_unit_if.master bus
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   lu_state_e      state_q, state_d;
   logic [CW-1:0]  cnt_q;
   logic           drop_q;
   logic           exc_q;
   logic [1:0]     off_q;
   load_size_e     op_q;
   logic [31:0]    ext_data;
   logic           accept;
   logic           fault;
   logic           timed_out;

   load_ext u_ext (
      .word   (bus.bus_rd_data),
      .offset (off_q),
      .op     (op_q),
      .data   (ext_data)
   );

   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      timed_out = 1'b0;
      fault     = load_fault(addr, op);
      case (state_q)
         LU_IDLE: begin
            if (req && (op != LOAD_NONE) && !flush) begin
               accept  = 1'b1;
               state_d = fault ? LU_DONE : LU_WAIT;
            end
         end
         LU_WAIT: begin
            // An ack in the final counted cycle still wins over the timeout.
            if (bus.bus_rd_ack || (cnt_q == CW'(TIMEOUT - 1))) begin
               timed_out = !bus.bus_rd_ack;
               state_d   = (drop_q || flush) ? LU_IDLE : LU_DONE;
            end
         end
         LU_DONE: state_d = LU_IDLE;
         default: state_d = LU_IDLE;
      endcase
   end

   // NOTE: all state is updated with non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= LU_IDLE;
         cnt_q          <= '0;
         drop_q         <= 1'b0;
         exc_q          <= 1'b0;
         off_q          <= 2'b00;
         op_q           <= LOAD_NONE;
         rdata          <= '0;
         bus.bus_rd_req <= 1'b0;
         bus.bus_addr   <= '0;
      end else begin
         state_q        <= state_d;
         bus.bus_rd_req <= (state_d == LU_WAIT);
         if (accept) begin
            off_q        <= addr[1:0];
            op_q         <= op;
            bus.bus_addr <= {addr[31:2], 2'b00};
            exc_q        <= fault;
            drop_q       <= 1'b0;
            cnt_q        <= '0;
            if (fault) rdata <= '0;
         end else if (state_q == LU_WAIT) begin
            // The bridge read cannot be cancelled; a flush only drops the result.
            if (flush) drop_q <= 1'b1;
            if (state_d == LU_DONE) begin
               exc_q <= timed_out;
               rdata <= timed_out ? '0 : ext_data;
            end
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

   assign ready     = (state_q == LU_IDLE);
   assign stall     = req && !ready;
   assign rvalid    = (state_q == LU_DONE) && !flush;
   assign exception = rvalid && exc_q;

endmodule

// File: tb/tb_load_unit.sv
// Self-checking bench for load_unit: a cycle-timeline reference model built
// from the load rules, random and directed loads, and a per-cycle comparator.
module tb_load_unit;
   import load_unit_pkg::*;

   localparam int TB_TO = 4;
   localparam int MAXC  = 4096;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req = 1'b0;
   logic [31:0] addr = '0;
   load_size_e  op = LOAD_NONE;
   logic        flush = 1'b0;
   logic        ready, stall, rvalid, exception;
   logic [31:0] rdata;

   load_unit_if bus ();

   load_unit #(.TIMEOUT(TB_TO)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (req),
      .addr      (addr),
      .op        (op),
      .flush     (flush),
      .ready     (ready),
      .stall     (stall),
      .rdata     (rdata),
      .rvalid    (rvalid),
      .exception (exception),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit chk_en = 1'b0;

   bit          exp_ready  [MAXC];
   bit          exp_breq   [MAXC];
   bit          exp_rvalid [MAXC];
   bit          exp_exc    [MAXC];
   logic [31:0] exp_baddr  [MAXC];
   logic [31:0] exp_rdata  [MAXC];

   logic [31:0] cap_rdata = '0;
   logic        cap_exc = 1'b0;
   int          cap_cyc = 0;
   int          rv_count = 0;
   int          breq_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference rules expressed as access size, alignment and address windows.
   function automatic bit ref_fault(input logic [31:0] a, input load_size_e o);
      bit tmr, ok;
      int sz;
      tmr = (a >= 32'h7F00 && a <= 32'h7F0B) || (a >= 32'h7F10 && a <= 32'h7F1B);
      ok  = (a < 32'h3000) || tmr || (a >= 32'h7F20 && a <= 32'h7F23);
      sz  = (o == LOAD_W) ? 4 : ((o == LOAD_H || o == LOAD_HU) ? 2 : 1);
      return !ok || ((int'(a[1:0]) % sz) != 0) || (tmr && sz != 4);
   endfunction

   function automatic logic [31:0] ref_ext(input logic [31:0] w, input logic [1:0] off,
                                           input load_size_e o);
      logic [31:0] v;
      case (o)
         LOAD_W: v = w;
         LOAD_B, LOAD_BU: begin
            v = (w >> (8 * off)) & 32'hFF;
            if (o == LOAD_B && v >= 32'h80) v = v | 32'hFFFF_FF00;
         end
         LOAD_H, LOAD_HU: begin
            v = (w >> (16 * (off / 2))) & 32'hFFFF;
            if (o == LOAD_H && v >= 32'h8000) v = v | 32'hFFFF_0000;
         end
         default: v = '0;
      endcase
      return v;
   endfunction

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      case ($urandom_range(0, 5))
         0: a = 32'($urandom_range(0, 32'h2FFF));
         1: a = 32'h7F00 + 32'($urandom_range(0, 31));
         2: a = 32'h7F20 + 32'($urandom_range(0, 7));
         3: a = 32'h2FF8 + 32'($urandom_range(0, 15));
         4: a = $urandom;
         default: a = 32'($urandom_range(0, 255));
      endcase
      return a;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic [31:0] a, input load_size_e o,
                        input logic f, input logic ack, input logic [31:0] dat);
      req = r;
      addr = a;
      op = o;
      flush = f;
      bus.bus_rd_ack = ack;
      bus.bus_rd_data = dat;
   endtask

   task automatic set_idle(input int c);
      exp_ready[c]  = 1'b1;
      exp_breq[c]   = 1'b0;
      exp_rvalid[c] = 1'b0;
      exp_exc[c]    = 1'b0;
      exp_baddr[c]  = '0;
      exp_rdata[c]  = '0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         set_idle(cyc);
         drive(1'b0, $urandom, LOAD_NONE, 1'b0, 1'b0, $urandom);
         tick();
      end
   endtask

   // A request the unit must not accept (LOAD_NONE or flush in IDLE).
   task automatic idle_req(input logic [31:0] a, input load_size_e o, input logic f);
      set_idle(cyc);
      drive(1'b1, a, o, f, 1'b0, $urandom);
      tick();
   endtask

   // One load issued in the current cycle. d: ack delay after the first request
   // cycle (<0: never). fl: cycle offset of a flush pulse (<0: none).
   task automatic do_load(input logic [31:0] a, input load_size_e o, input int d,
                          input int fl, input logic [31:0] ad);
      int k, len, end_c, hor, ack_c;
      bit flt, tmo, dropped;
      k       = cyc;
      flt     = ref_fault(a, o);
      ack_c   = (d >= 0) ? d + 1 : -1;
      tmo     = !flt && (d < 0 || d >= TB_TO);
      len     = flt ? 0 : (tmo ? TB_TO : d + 1);
      dropped = !flt && fl >= 1 && fl <= len;
      end_c   = dropped ? len : len + 1;
      hor     = (ack_c > end_c + 1) ? ack_c : end_c + 1;
      for (int c = 0; c <= hor; c++) begin
         exp_ready[k+c]  = (c == 0) || (c > end_c);
         exp_breq[k+c]   = (c >= 1) && (c <= len);
         exp_baddr[k+c]  = a & ~32'h3;
         exp_rvalid[k+c] = !dropped && (c == len + 1) && (c != fl);
         exp_exc[k+c]    = exp_rvalid[k+c] && (flt || tmo);
         exp_rdata[k+c]  = (flt || tmo) ? 32'h0 : ref_ext(ad, a[1:0], o);
      end
      for (int c = 0; c <= hor; c++) begin
         drive(c <= end_c, a, o, c == fl, c == ack_c, (c == ack_c) ? ad : $urandom);
         tick();
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rvalid) begin
         cap_rdata <= rdata;
         cap_exc   <= exception;
         cap_cyc   <= cyc;
         rv_count  <= rv_count + 1;
      end
      if (bus.bus_rd_req) breq_cnt <= breq_cnt + 1;
   end

   // Per-cycle comparator against the timeline model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("ready", 32'(ready), 32'(exp_ready[cyc]));
         check("stall", 32'(stall), 32'(req && !exp_ready[cyc]));
         check("bus_rd_req", 32'(bus.bus_rd_req), 32'(exp_breq[cyc]));
         check("rvalid", 32'(rvalid), 32'(exp_rvalid[cyc]));
         check("exception", 32'(exception), 32'(exp_exc[cyc]));
         if (exp_breq[cyc]) check("bus_addr", bus.bus_addr, exp_baddr[cyc]);
         if (exp_rvalid[cyc]) check("rdata", rdata, exp_rdata[cyc]);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int k, b0, r0, d, fl;
      logic [31:0] a;
      load_size_e o;

      bus.bus_rd_ack = 1'b0;
      bus.bus_rd_data = '0;

      // Model pins against hand-computed values.
      check("pin ext B", ref_ext(32'h80FF_1234, 2'd3, LOAD_B), 32'hFFFF_FF80);
      check("pin ext HU", ref_ext(32'h8001_0000, 2'd2, LOAD_HU), 32'h0000_8001);
      check("pin ext H", ref_ext(32'h0000_9ABC, 2'd0, LOAD_H), 32'hFFFF_9ABC);
      check("pin fault H odd", 32'(ref_fault(32'h1, LOAD_H)), 32'd1);
      check("pin fault timer W", 32'(ref_fault(32'h7F08, LOAD_W)), 32'd0);
      check("pin fault INT B", 32'(ref_fault(32'h7F21, LOAD_BU)), 32'd0);

      #2;
      check("reset ready", 32'(ready), 32'd1);
      check("reset bus_rd_req", 32'(bus.bus_rd_req), 32'd0);
      check("reset bus_addr", bus.bus_addr, 32'h0);
      check("reset rdata", rdata, 32'h0);
      check("reset rvalid", 32'(rvalid), 32'd0);
      check("reset exception", 32'(exception), 32'd0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      tick();
      chk_en = 1'b1;
      idle(2);

      // LOAD_B at 0x3, ack in the first request cycle.
      k = cyc;
      do_load(32'h3, LOAD_B, 0, -1, 32'h80FF_1234);
      check("tp1 rdata", cap_rdata, 32'hFFFF_FF80);
      check("tp1 exception", 32'(cap_exc), 32'd0);
      check("tp1 latency", 32'(cap_cyc - k), 32'd2);

      do_load(32'h2, LOAD_HU, 1, -1, 32'h8001_0000);
      check("tp2 rdata", cap_rdata, 32'h0000_8001);

      k = cyc;
      b0 = breq_cnt;
      do_load(32'h1, LOAD_H, 0, -1, 32'h1111_1111);
      check("tp2 H misaligned exc", 32'(cap_exc), 32'd1);
      check("tp2 H exc latency", 32'(cap_cyc - k), 32'd1);
      check("tp2 H no bus req", 32'(breq_cnt - b0), 32'd0);

      do_load(32'h7F08, LOAD_B, 0, -1, 32'h0);
      check("tp3 timer B exc", 32'(cap_exc), 32'd1);
      do_load(32'h7F08, LOAD_W, 2, -1, 32'h0000_0005);
      check("tp3 timer W rdata", cap_rdata, 32'h5);
      check("tp3 timer W exc", 32'(cap_exc), 32'd0);
      do_load(32'h3000, LOAD_W, 0, -1, 32'h0);
      check("tp3 0x3000 exc", 32'(cap_exc), 32'd1);

      b0 = breq_cnt;
      do_load(32'h10, LOAD_W, -1, -1, 32'h0);
      check("tp4 timeout req cycles", 32'(breq_cnt - b0), 32'd4);
      check("tp4 timeout exc", 32'(cap_exc), 32'd1);
      check("tp4 timeout rdata", cap_rdata, 32'h0);
      do_load(32'h20, LOAD_W, TB_TO - 1, -1, 32'hCAFE_F00D);
      check("tp4 last-cycle ack rdata", cap_rdata, 32'hCAFE_F00D);
      check("tp4 last-cycle ack exc", 32'(cap_exc), 32'd0);

      r0 = rv_count;
      do_load(32'h40, LOAD_W, 3, 2, 32'hDEAD_BEEF);
      check("tp5 flushed no rvalid", 32'(rv_count - r0), 32'd0);
      do_load(32'h44, LOAD_W, 1, -1, 32'h1234_5678);
      check("tp5 next load rdata", cap_rdata, 32'h1234_5678);
      check("tp5 next load rvalid", 32'(rv_count - r0), 32'd1);
      idle_req(32'h8, LOAD_W, 1'b1);
      idle_req(32'h8, LOAD_NONE, 1'b0);
      idle(1);

      // Randomized loads against the timeline model.
      for (int n = 0; n < 250 && cyc < MAXC - 64; n++) begin
         case ($urandom_range(0, 9))
            7: idle_req(rand_addr(), ($urandom_range(0, 1) == 1) ? LOAD_NONE
                        : load_size_e'($urandom_range(1, 5)), 1'b1);
            8, 9: idle(int'($urandom_range(1, 3)));
            default: begin
               a = rand_addr();
               o = load_size_e'($urandom_range(1, 5));
               case ($urandom_range(0, 9))
                  0: d = -1;
                  1: d = TB_TO + int'($urandom_range(0, 2));
                  default: d = int'($urandom_range(0, TB_TO - 1));
               endcase
               fl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 6)) : -1;
               do_load(a, o, d, fl, $urandom);
            end
         endcase
      end

      // Reset asserted while a read is outstanding.
      chk_en = 1'b0;
      drive(1'b1, 32'h1234, LOAD_W, 1'b0, 1'b0, $urandom);
      tick();
      drive(1'b0, 32'h1234, LOAD_W, 1'b0, 1'b0, $urandom);
      tick();
      check("pre-reset in WAIT", 32'(bus.bus_rd_req), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("async reset ready", 32'(ready), 32'd1);
      check("async reset bus_rd_req", 32'(bus.bus_rd_req), 32'd0);
      check("async reset bus_addr", bus.bus_addr, 32'h0);
      check("async reset rdata", rdata, 32'h0);
      check("async reset rvalid", 32'(rvalid), 32'd0);
      check("async reset exception", 32'(exception), 32'd0);
      #1 reset_n = 1'b1;
      drive(1'b0, 32'h0, LOAD_NONE, 1'b0, 1'b1, 32'hFFFF_FFFF);
      tick();
      drive(1'b0, 32'h0, LOAD_NONE, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 2; i++) begin
         check("late ack ignored rvalid", 32'(rvalid), 32'd0);
         check("late ack ignored ready", 32'(ready), 32'd1);
         check("late ack ignored bus_rd_req", 32'(bus.bus_rd_req), 32'd0);
         tick();
      end
      chk_en = 1'b1;
      do_load(32'h7F20, LOAD_BU, 0, -1, 32'h0000_00A5);
      check("post-reset INT load", cap_rdata, 32'h0000_00A5);
      chk_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
